// File: rtl/std_mem_arbiter_2.sv
// Two-into-one std_mem request arbiter with a registered request stage and
// in-order read-response routing driven by a small order-tracking FIFO.
module std_mem_arbiter_2 #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 1,
    parameter int ORDER_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    request0_valid_i,
    output logic                    request0_ready_o,
    input  logic                    request0_read_enable_i,
    input  logic [DATA_WIDTH/8-1:0] request0_write_enable_i,
    input  logic [ADDR_WIDTH-1:0]   request0_addr_i,
    input  logic [DATA_WIDTH-1:0]   request0_data_i,
    input  logic [ID_WIDTH-1:0]     request0_id_i,

    input  logic                    request1_valid_i,
    output logic                    request1_ready_o,
    input  logic                    request1_read_enable_i,
    input  logic [DATA_WIDTH/8-1:0] request1_write_enable_i,
    input  logic [ADDR_WIDTH-1:0]   request1_addr_i,
    input  logic [DATA_WIDTH-1:0]   request1_data_i,
    input  logic [ID_WIDTH-1:0]     request1_id_i,

    output logic                    response0_valid_o,
    input  logic                    response0_ready_i,
    output logic [DATA_WIDTH-1:0]   response0_data_o,
    output logic [ID_WIDTH-1:0]     response0_id_o,

    output logic                    response1_valid_o,
    input  logic                    response1_ready_i,
    output logic [DATA_WIDTH-1:0]   response1_data_o,
    output logic [ID_WIDTH-1:0]     response1_id_o,

    output logic                    mem_request_valid_o,
    input  logic                    mem_request_ready_i,
    output logic                    mem_request_read_enable_o,
    output logic [DATA_WIDTH/8-1:0] mem_request_write_enable_o,
    output logic [ADDR_WIDTH-1:0]   mem_request_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_request_data_o,
    output logic [ID_WIDTH-1:0]     mem_request_id_o,

    input  logic                    mem_response_valid_i,
    output logic                    mem_response_ready_o,
    input  logic [DATA_WIDTH-1:0]   mem_response_data_i,
    input  logic [ID_WIDTH-1:0]     mem_response_id_i
);
    localparam int PTR_W = $clog2(ORDER_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WE_W  = DATA_WIDTH / 8;

    logic                   valid_q, valid_d;
    logic                   re_q, re_d;
    logic [WE_W-1:0]        we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic                   prio_q, prio_d;

    logic [ORDER_DEPTH-1:0] order_q, order_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic fifo_empty, fifo_full, head, pop, push, full_block;
    logic elig0, elig1, any_elig, grant_idx, load_ok, load, grant_re;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(ORDER_DEPTH));
    assign head       = order_q[rd_ptr_q];

    assign mem_response_ready_o = (head ? response1_ready_i : response0_ready_i) && !fifo_empty;
    assign pop                  = mem_response_valid_i && mem_response_ready_o;

    assign response0_valid_o = mem_response_valid_i && !fifo_empty && !head;
    assign response1_valid_o = mem_response_valid_i && !fifo_empty && head;
    assign response0_data_o  = mem_response_data_i;
    assign response1_data_o  = mem_response_data_i;
    assign response0_id_o    = mem_response_id_i;
    assign response1_id_o    = mem_response_id_i;

    // A read may take the slot being freed by a response popped this cycle.
    assign full_block = fifo_full && !pop;
    assign elig0      = request0_valid_i && (!request0_read_enable_i || !full_block);
    assign elig1      = request1_valid_i && (!request1_read_enable_i || !full_block);
    assign any_elig   = elig0 || elig1;
    assign grant_idx  = (elig0 && elig1) ? prio_q : elig1;
    assign grant_re   = grant_idx ? request1_read_enable_i : request0_read_enable_i;

    assign load_ok = !valid_q || mem_request_ready_i;
    assign load    = load_ok && any_elig && !rst;
    assign push    = load && grant_re;

    assign request0_ready_o = load && !grant_idx;
    assign request1_ready_o = load && grant_idx;

    assign mem_request_valid_o        = valid_q;
    assign mem_request_read_enable_o  = re_q;
    assign mem_request_write_enable_o = we_q;
    assign mem_request_addr_o         = addr_q;
    assign mem_request_data_o         = data_q;
    assign mem_request_id_o           = id_q;

    always_comb begin
        valid_d  = valid_q;
        re_d     = re_q;
        we_d     = we_q;
        addr_d   = addr_q;
        data_d   = data_q;
        id_d     = id_q;
        prio_d   = prio_q;
        order_d  = order_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        if (load_ok) valid_d = any_elig;
        if (load) begin
            re_d   = grant_re;
            we_d   = grant_idx ? request1_write_enable_i : request0_write_enable_i;
            addr_d = grant_idx ? request1_addr_i : request0_addr_i;
            data_d = grant_idx ? request1_data_i : request0_data_i;
            id_d   = grant_idx ? request1_id_i : request0_id_i;
            if (elig0 && elig1) prio_d = !grant_idx;
        end
        if (push) begin
            order_d[wr_ptr_q] = grant_idx;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            re_q     <= 1'b0;
            we_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            id_q     <= '0;
            prio_q   <= 1'b0;
            order_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            re_q     <= re_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            id_q     <= id_d;
            prio_q   <= prio_d;
            order_q  <= order_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Memory must never answer a read that was never issued.
    a_resp_without_read: assert property (@(posedge clk) disable iff (rst)
        !(mem_response_valid_i && fifo_empty));

endmodule

// File: tb/tb_std_mem_arbiter_2.sv
// Directed bench for std_mem_arbiter_2: a cycle table for grant/routing
// behaviour plus hand sequences for backpressure, FIFO-full and reset.
module tb_std_mem_arbiter_2;
    logic        clk = 1'b0;
    logic        rst;
    logic        r0v, r0rdy, r0re, r1v, r1rdy, r1re;
    logic [3:0]  r0we, r1we;
    logic [31:0] r0a, r0d, r1a, r1d;
    logic [0:0]  r0id, r1id;
    logic        p0v, p0rdy, p1v, p1rdy;
    logic [31:0] p0d, p1d;
    logic [0:0]  p0id, p1id;
    logic        mv, mrdy, mre;
    logic [3:0]  mwe;
    logic [31:0] ma, md;
    logic [0:0]  mid;
    logic        rspv, rsprdy;
    logic [31:0] rspd;
    logic [0:0]  rspid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    std_mem_arbiter_2 dut (
        .clk(clk), .rst(rst),
        .request0_valid_i(r0v), .request0_ready_o(r0rdy), .request0_read_enable_i(r0re),
        .request0_write_enable_i(r0we), .request0_addr_i(r0a), .request0_data_i(r0d), .request0_id_i(r0id),
        .request1_valid_i(r1v), .request1_ready_o(r1rdy), .request1_read_enable_i(r1re),
        .request1_write_enable_i(r1we), .request1_addr_i(r1a), .request1_data_i(r1d), .request1_id_i(r1id),
        .response0_valid_o(p0v), .response0_ready_i(p0rdy), .response0_data_o(p0d), .response0_id_o(p0id),
        .response1_valid_o(p1v), .response1_ready_i(p1rdy), .response1_data_o(p1d), .response1_id_o(p1id),
        .mem_request_valid_o(mv), .mem_request_ready_i(mrdy), .mem_request_read_enable_o(mre),
        .mem_request_write_enable_o(mwe), .mem_request_addr_o(ma), .mem_request_data_o(md), .mem_request_id_o(mid),
        .mem_response_valid_i(rspv), .mem_response_ready_o(rsprdy),
        .mem_response_data_i(rspd), .mem_response_id_i(rspid)
    );

    typedef struct {
        logic        r0v; logic r0re; logic [3:0] r0we; logic [31:0] r0a;
        logic        r1v; logic r1re; logic [31:0] r1a;
        logic        mrdy; logic rspv; logic [31:0] rspd;
        logic        e0rdy; logic e1rdy;
        logic        emv; logic [31:0] ema; logic [3:0] ewe; logic [31:0] emd;
        logic        e0v; logic e1v; logic [31:0] erd;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        r0v = 0; r0re = 0; r0we = 0; r0a = 0;
        r1v = 0; r1re = 0; r1we = 0; r1a = 0;
        mrdy = 1; rspv = 0; rspd = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        r0d = 32'h42; r1d = 32'h99; r0id = 1'b0; r1id = 1'b1;
        p0rdy = 1; p1rdy = 1; rspid = 1'b0;
        idle();
        rst = 1;

        //            r0v  r0re  r0we   r0a       r1v  r1re  r1a       mrdy rspv rspd     e0r  e1r  emv  ema       ewe   emd       e0v  e1v  erd
        vecs[0]  = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,  1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b0,1'b0,32'h0};
        vecs[1]  = '{1'b1,1'b0,4'hF,32'h10,  1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,  1'b1,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b0,1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,  1'b0,1'b0,1'b1,32'h10,  4'hF,32'h42, 1'b0,1'b0,32'h0};
        vecs[3]  = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,  1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b0,1'b0,32'h0};
        vecs[4]  = '{1'b1,1'b1,4'h0,32'h100, 1'b1,1'b1,32'h200, 1'b1,1'b0,32'h0,  1'b1,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b0,1'b0,32'h0};
        vecs[5]  = '{1'b1,1'b1,4'h0,32'h100, 1'b1,1'b1,32'h200, 1'b1,1'b0,32'h0,  1'b0,1'b1,1'b1,32'h100, 4'h0,32'h42, 1'b0,1'b0,32'h0};
        vecs[6]  = '{1'b1,1'b1,4'h0,32'h100, 1'b1,1'b1,32'h200, 1'b1,1'b0,32'h0,  1'b1,1'b0,1'b1,32'h200, 4'h0,32'h99, 1'b0,1'b0,32'h0};
        vecs[7]  = '{1'b1,1'b1,4'h0,32'h100, 1'b1,1'b1,32'h200, 1'b1,1'b0,32'h0,  1'b0,1'b1,1'b1,32'h100, 4'h0,32'h42, 1'b0,1'b0,32'h0};
        vecs[8]  = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,  1'b0,1'b0,1'b1,32'h200, 4'h0,32'h99, 1'b0,1'b0,32'h0};
        vecs[9]  = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b1,32'hA0, 1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b1,1'b0,32'hA0};
        vecs[10] = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b1,32'hA1, 1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b0,1'b1,32'hA1};
        vecs[11] = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b1,32'hA2, 1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b1,1'b0,32'hA2};
        vecs[12] = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b1,32'hA3, 1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b0,1'b1,32'hA3};
        vecs[13] = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,  1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b0,1'b0,32'h0};
        vecs[14] = '{1'b0,1'b0,4'h0,32'h0,   1'b1,1'b1,32'h8,   1'b1,1'b0,32'h0,  1'b0,1'b1,1'b0,32'h0,   4'h0,32'h0,  1'b0,1'b0,32'h0};
        vecs[15] = '{1'b1,1'b1,4'h0,32'h4,   1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,  1'b1,1'b0,1'b1,32'h8,   4'h0,32'h99, 1'b0,1'b0,32'h0};
        vecs[16] = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,  1'b0,1'b0,1'b1,32'h4,   4'h0,32'h42, 1'b0,1'b0,32'h0};
        vecs[17] = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b1,32'h10, 1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b0,1'b1,32'h10};
        vecs[18] = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b1,32'h08, 1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b1,1'b0,32'h08};
        vecs[19] = '{1'b0,1'b0,4'h0,32'h0,   1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,  1'b0,1'b0,1'b0,32'h0,   4'h0,32'h0,  1'b0,1'b0,32'h0};

        // Reset state, with a request waiting that must not be acknowledged.
        repeat (2) next_cycle();
        r0v = 1; r0we = 4'hF; r0a = 32'h10;
        #1;
        chk("rst_mem_valid", 32'(mv), 0);
        chk("rst_req0_ready", 32'(r0rdy), 0);
        chk("rst_resp_valids", {30'd0, p1v, p0v}, 0);
        next_cycle();
        idle();
        rst = 0;

        for (int i = 0; i < 20; i++) begin
            r0v = vecs[i].r0v; r0re = vecs[i].r0re; r0we = vecs[i].r0we; r0a = vecs[i].r0a;
            r1v = vecs[i].r1v; r1re = vecs[i].r1re; r1a = vecs[i].r1a;
            mrdy = vecs[i].mrdy; rspv = vecs[i].rspv; rspd = vecs[i].rspd;
            #1;
            chk($sformatf("v%0d_req0_ready", i), 32'(r0rdy), 32'(vecs[i].e0rdy));
            chk($sformatf("v%0d_req1_ready", i), 32'(r1rdy), 32'(vecs[i].e1rdy));
            chk($sformatf("v%0d_mem_valid", i), 32'(mv), 32'(vecs[i].emv));
            chk($sformatf("v%0d_resp0_valid", i), 32'(p0v), 32'(vecs[i].e0v));
            chk($sformatf("v%0d_resp1_valid", i), 32'(p1v), 32'(vecs[i].e1v));
            if (vecs[i].emv) begin
                chk($sformatf("v%0d_mem_addr", i), ma, vecs[i].ema);
                chk($sformatf("v%0d_mem_we", i), 32'(mwe), 32'(vecs[i].ewe));
                chk($sformatf("v%0d_mem_data", i), md, vecs[i].emd);
            end
            if (vecs[i].e0v) chk($sformatf("v%0d_resp0_data", i), p0d, vecs[i].erd);
            if (vecs[i].e1v) chk($sformatf("v%0d_resp1_data", i), p1d, vecs[i].erd);
            next_cycle();
        end

        // Backpressure: held beat stays put, nobody is acknowledged.
        idle();
        r0v = 1; r0we = 4'hF; r0a = 32'h50;
        #1; chk("bp_first_load", 32'(r0rdy), 1);
        next_cycle();
        r0a = 32'h60; r1v = 1; r1we = 4'h3; r1a = 32'h70; mrdy = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_ready", k), {30'd0, r1rdy, r0rdy}, 0);
            chk($sformatf("bp%0d_mem_addr", k), ma, 32'h50);
            chk($sformatf("bp%0d_mem_valid", k), 32'(mv), 1);
            next_cycle();
        end
        mrdy = 1;
        #1;
        chk("bp_release_ready0", 32'(r0rdy), 1);
        chk("bp_release_addr", ma, 32'h50);
        next_cycle();
        r0v = 0;
        #1;
        chk("bp_after_addr", ma, 32'h60);
        chk("bp_req1_ready", 32'(r1rdy), 1);
        next_cycle();
        idle();
        #1; chk("bp_last_addr", ma, 32'h70);
        next_cycle();

        // FIFO full: four reads outstanding, fifth read waits, writes still pass.
        for (int k = 0; k < 4; k++) begin
            r0v = 1; r0re = 1; r0a = 32'h500 + 32'(4 * k);
            #1; chk($sformatf("full_fill%0d_ready", k), 32'(r0rdy), 1);
            next_cycle();
        end
        r0a = 32'h510; r1v = 1; r1we = 4'hF; r1a = 32'h600;
        #1;
        chk("full_read_stalled", 32'(r0rdy), 0);
        chk("full_write_passes", 32'(r1rdy), 1);
        next_cycle();
        r1v = 0; r1we = 0;
        #1;
        chk("full_still_stalled", 32'(r0rdy), 0);
        chk("full_write_addr", ma, 32'h600);
        next_cycle();
        rspv = 1; rspd = 32'hB0;
        #1;
        chk("full_pop_resp0", 32'(p0v), 1);
        chk("full_pop_frees_slot", 32'(r0rdy), 1);
        next_cycle();
        r0v = 0; r0re = 0; rspv = 0;
        #1;
        chk("full_fifth_addr", ma, 32'h510);
        chk("full_fifth_is_read", 32'(mre), 1);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            rspv = 1; rspd = 32'hC0 + 32'(k);
            #1;
            chk($sformatf("full_drain%0d_resp0", k), 32'(p0v), 1);
            chk($sformatf("full_drain%0d_data", k), p0d, 32'hC0 + 32'(k));
            next_cycle();
        end
        rspv = 0;

        // Reset with two reads outstanding and a write held.
        r0v = 1; r0re = 1; r0a = 32'h300; next_cycle();
        r0a = 32'h304; next_cycle();
        r0re = 0; r0we = 4'hF; r0a = 32'h308; next_cycle();
        idle(); mrdy = 0; r0v = 1; r0we = 4'hF; r0a = 32'h30C;
        #1; chk("pre_rst_held", ma, 32'h308);
        next_cycle();
        rst = 1; rspv = 1; rspd = 32'hDD;
        #1;
        chk("mid_rst_mem_valid", 32'(mv), 0);
        chk("mid_rst_resp_valids", {30'd0, p1v, p0v}, 0);
        chk("mid_rst_mem_resp_ready", 32'(rsprdy), 0);
        chk("mid_rst_req_ready", 32'(r0rdy), 0);
        next_cycle();
        idle();
        rst = 0;
        r1v = 1; r1re = 1; r1a = 32'h400;
        #1; chk("post_rst_req1_ready", 32'(r1rdy), 1);
        next_cycle();
        r1v = 0; r1re = 0;
        #1;
        chk("post_rst_addr", ma, 32'h400);
        chk("post_rst_mem_valid", 32'(mv), 1);
        next_cycle();
        rspv = 1; rspd = 32'h77;
        #1;
        chk("post_rst_resp1", {30'd0, p1v, p0v}, 32'h2);
        chk("post_rst_resp1_data", p1d, 32'h77);
        next_cycle();
        rspv = 0;
        #1; chk("post_rst_fifo_empty", 32'(rsprdy), 0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
